// File: rtl/and_unit_arbiter_pkg.sv
// Shared constants for the AND-unit arbiter: output-slot state encoding and default sizes.
package and_unit_arbiter_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 8;

endpackage

// File: rtl/and_unit_arbiter_and_word.sv
// Shared W-bit bitwise AND datapath; purely combinational.
module and_word #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = a & b;

endmodule

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter sharing one AND datapath between N requesters, with a
// single registered output slot (result + requester id) and valid/ready handshakes.
module and_unit_arbiter
    import and_unit_arbiter_pkg::*;
#(
    parameter int N   = DEFAULT_N,
    parameter int W   = DEFAULT_W,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    output logic [N-1:0]     req_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [W-1:0]     resp_data,
    output logic [IDW-1:0]   resp_id
);

    arb_state_e     state_reg, state_next;
    logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [W-1:0]   resp_data_reg, resp_data_next;
    logic [IDW-1:0] resp_id_reg, resp_id_next;

    logic [W-1:0]   a_words [N];
    logic [W-1:0]   b_words [N];
    logic [W-1:0]   and_result;

    logic           can_accept;
    logic           grant_found;
    logic           grant;
    logic [IDW-1:0] winner;
    int             idx;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign a_words[gi] = req_a[gi*W +: W];
            assign b_words[gi] = req_b[gi*W +: W];
        end
    endgenerate

    and_word #(.W(W)) u_and_word (
        .a (a_words[winner]),
        .b (b_words[winner]),
        .y (and_result)
    );

    // Reset also blocks grants so no requester believes its pair was consumed.
    assign can_accept = !rst && ((state_reg == EMPTY) || resp_ready);
    assign grant      = can_accept && grant_found;

    // Scan starting at rr_ptr, wrapping modulo N; first pending requester wins.
    always_comb begin
        grant_found = 1'b0;
        winner      = '0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                winner      = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready = N'(1) << winner;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        resp_data_next = resp_data_reg;
        resp_id_next   = resp_id_reg;
        if (grant) begin
            state_next     = FULL;
            resp_data_next = and_result;
            resp_id_next   = winner;
            rr_ptr_next    = (winner == IDW'(N - 1)) ? '0 : winner + IDW'(1);
        end else if (state_reg == FULL && resp_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= EMPTY;
            rr_ptr_reg    <= '0;
            resp_data_reg <= '0;
            resp_id_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            resp_data_reg <= resp_data_next;
            resp_id_reg   <= resp_id_next;
        end
    end

    assign resp_valid = (state_reg == FULL);
    assign resp_data  = resp_data_reg;
    assign resp_id    = resp_id_reg;

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Scoreboard bench for and_unit_arbiter: a stimulus process predicts grants and
// results from a queue-based model, a monitor pops and compares consumed results.
module tb_and_unit_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             resp_valid;
    logic             resp_ready;
    logic [W-1:0]     resp_data;
    logic [IDW-1:0]   resp_id;

    and_unit_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [W-1:0] data;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: whether the output slot is occupied and the scan start.
    int   m_rr     = 0;
    bit   m_full   = 0;
    bit   prev_rst = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] put_word(input logic [N*W-1:0] v, input int i,
                                                input logic [W-1:0] w);
        logic [N*W-1:0] r;
        r = v;
        r[i*W +: W] = w;
        return r;
    endfunction

    // One clock cycle: drive at the falling edge, then predict and compare.
    task automatic cycle(input logic r, input logic [N-1:0] v, input logic rr,
                         input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        int           w;
        int           j;
        bit           can;
        logic [N-1:0] exp_rdy;
        exp_t         e;
        @(negedge clk);
        rst        = r;
        req_valid  = v;
        resp_ready = rr;
        req_a      = a;
        req_b      = b;
        #1;
        w = -1;
        for (int k = 0; k < N; k++) begin
            j = (m_rr + k) % N;
            if (w < 0 && v[j]) w = j;
        end
        can     = !m_full || rr;
        exp_rdy = '0;
        if (!r && can && w >= 0) exp_rdy[w] = 1'b1;

        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("resp_valid", 32'(resp_valid), 32'(m_full));
        if (prev_rst) begin
            check("rst_resp_data", 32'(resp_data), 32'h0);
            check("rst_resp_id", 32'(resp_id), 32'h0);
        end else if (m_full && q.size() > 0) begin
            check("held_resp_data", 32'(resp_data), 32'(q[0].data));
        end
        $display("cycle t=%0t rst=%0b v=%b rr=%0b req_ready=%b resp_valid=%0b id=%0d data=%h",
                 $time, r, v, rr, req_ready, resp_valid, resp_id, resp_data);

        if (r) begin
            m_full = 0;
            m_rr   = 0;
            q.delete();
        end else if (exp_rdy != '0) begin
            e.id   = w;
            e.data = a[w*W +: W] & b[w*W +: W];
            q.push_back(e);
            m_full = 1;
            m_rr   = (w + 1) % N;
        end else if (m_full && rr) begin
            m_full = 0;
        end
        prev_rst = r;
    endtask

    // Monitor: a result is consumed when valid and ready meet at the coming edge.
    always begin
        @(negedge clk);
        #2;
        if (!rst && resp_valid === 1'b1 && resp_ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual_id=%0d data=%h expected none", resp_id, resp_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("resp_id", 32'(resp_id), 32'(e.id));
                check("resp_data", 32'(resp_data), 32'(e.data));
            end
        end
    end

    logic [N*W-1:0] a_v, b_v;

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        req_a      = '0;
        req_b      = '0;

        // Reset held with every requester pending.
        repeat (2) cycle(1'b1, 4'b1111, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Single request from requester 2.
        a_v = put_word('0, 2, 8'hF0);
        b_v = put_word('0, 2, 8'h3C);
        cycle(1'b0, 4'b0100, 1'b1, a_v, b_v);
        cycle(1'b0, 4'b0000, 1'b1, '0, '0);

        // Round-robin from a fresh pointer, no idle cycles.
        cycle(1'b1, 4'b0000, 1'b0, '0, '0);
        repeat (6) cycle(1'b0, 4'b1111, 1'b1, 32'($urandom), 32'($urandom));
        cycle(1'b0, 4'b0000, 1'b1, '0, '0);

        // Backpressure: fill, stall three cycles, then release.
        cycle(1'b0, 4'b0011, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF);
        repeat (3) cycle(1'b0, 4'b0011, 1'b0, 32'($urandom), 32'($urandom));
        cycle(1'b0, 4'b0011, 1'b1, 32'($urandom), 32'($urandom));
        cycle(1'b0, 4'b0000, 1'b1, '0, '0);

        // Pointer wrap: 3, then 0, then 3.
        cycle(1'b0, 4'b1000, 1'b1, 32'($urandom), 32'($urandom));
        cycle(1'b0, 4'b1001, 1'b1, 32'($urandom), 32'($urandom));
        cycle(1'b0, 4'b1001, 1'b1, 32'($urandom), 32'($urandom));
        cycle(1'b0, 4'b0000, 1'b1, '0, '0);

        // Reset while holding 8'hAA; result discarded and pointer restarts at 0.
        a_v = put_word('0, 1, 8'hAA);
        b_v = put_word('0, 1, 8'hFF);
        cycle(1'b0, 4'b0010, 1'b0, a_v, b_v);
        cycle(1'b0, 4'b0000, 1'b0, '0, '0);
        cycle(1'b1, 4'b1111, 1'b0, '0, '0);
        cycle(1'b0, 4'b1111, 1'b1, 32'($urandom), 32'($urandom));

        // Randomized traffic with occasional resets.
        for (int t = 0; t < 2000; t++) begin
            cycle(($urandom_range(0, 99) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
                  32'($urandom), 32'($urandom));
        end

        repeat (3) cycle(1'b0, 4'b0000, 1'b1, '0, '0);
        check("queue_drained", 32'(q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
